// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared state encoding and default pattern for seq_gen and the pattern detectors
package seq_gen_pkg;

  localparam int          DEF_PAT_W = 4;
  localparam logic [3:0]  DEF_PAT   = 4'b1011;
  localparam int          DEF_CNT_W = 8;

  // PAR is only reachable with SEQ_GEN_PARITY_EN, but the encoding is fixed so detectors agree.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_bit_ctr.sv
// rtl/seq_bit_ctr.sv - bit-index and frame down-counters for seq_gen
module seq_bit_ctr #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] frames,
  input  logic             step,
  input  logic             next_frame,
  output logic [IDX_W-1:0] bit_idx,
  output logic             last_bit,
  output logic             last_frame
);

  logic [IDX_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] frame_q, frame_d;

  // frame_q holds frames remaining after the one on the wire, so it never wraps.
  always_comb begin
    bit_d   = bit_q;
    frame_d = frame_q;
    if (load) begin
      bit_d   = IDX_W'(PAT_W - 1);
      frame_d = (frames == '0) ? '0 : frames - CNT_W'(1);
    end else if (next_frame) begin
      bit_d   = IDX_W'(PAT_W - 1);
      frame_d = frame_q - CNT_W'(1);
    end else if (step) begin
      bit_d   = bit_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q   <= '0;
      frame_q <= '0;
    end else begin
      bit_q   <= bit_d;
      frame_q <= frame_d;
    end
  end

  assign bit_idx    = bit_q;
  assign last_bit   = (bit_q == '0);
  assign last_frame = (frame_q == '0);

endmodule

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial pattern generator, MSB first, bursts of repeat_cnt frames
// Optional even-parity bit per frame when SEQ_GEN_PARITY_EN is defined.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT   = DEF_PAT,
  parameter int               CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_pat,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ctr_load, ctr_step, ctr_next_frame;
  logic [IDX_W-1:0] bit_idx;
  logic             last_bit, last_frame;

  seq_bit_ctr #(.PAT_W(PAT_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ctr_load),
    .frames     (repeat_cnt),
    .step       (ctr_step),
    .next_frame (ctr_next_frame),
    .bit_idx    (bit_idx),
    .last_bit   (last_bit),
    .last_frame (last_frame)
  );

  // Outputs are computed for the next cycle so dout/dvalid line up with the state they describe.
  always_comb begin
    state_d        = state_q;
    pat_d          = pat_q;
    dout_d         = 1'b0;
    dvalid_d       = 1'b0;
    done_d         = 1'b0;
    ctr_load       = 1'b0;
    ctr_step       = 1'b0;
    ctr_next_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_pat) pat_d = pat_in;
        if (start) begin
          ctr_load = 1'b1;
          if (repeat_cnt == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_SHIFT;
            dvalid_d = 1'b1;
            dout_d   = pat_d[PAT_W-1];
          end
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          ctr_step = 1'b1;
          dvalid_d = 1'b1;
          dout_d   = pat_q[bit_idx - IDX_W'(1)];
        end
`ifdef SEQ_GEN_PARITY_EN
        else begin
          state_d  = ST_PAR;
          dvalid_d = 1'b1;
          dout_d   = ^pat_q;
        end
`else
        else if (!last_frame) begin
          ctr_next_frame = 1'b1;
          dvalid_d       = 1'b1;
          dout_d         = pat_q[PAT_W-1];
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PAR: begin
        if (!last_frame) begin
          state_d        = ST_SHIFT;
          ctr_next_frame = 1'b1;
          dvalid_d       = 1'b1;
          dout_d         = pat_q[PAT_W-1];
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pat_q    <= PAT;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - self-checking bench for seq_gen; frame length follows SEQ_GEN_PARITY_EN
module tb_seq_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             load_pat;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] repeat_cnt;
  logic             dout, dvalid, busy, done;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  seq_gen #(.PAT_W(PAT_W), .PAT(4'b1011), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_pat   (load_pat),
    .pat_in     (pat_in),
    .repeat_cnt (repeat_cnt),
    .dout       (dout),
    .dvalid     (dvalid),
    .busy       (busy),
    .done       (done)
  );

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_frames(input logic [PAT_W-1:0] p, input int n);
    for (int f = 0; f < n; f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(p[b]);
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back(^p);
`endif
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n, input bit ld, input logic [PAT_W-1:0] p);
    load_pat   = ld;
    pat_in     = p;
    repeat_cnt = n;
    start      = 1'b1;
    cycle();
    start    = 1'b0;
    load_pat = 1'b0;
  endtask

  // Called right after the accepting edge; compares every valid bit against the queue.
  task automatic collect(input string name, input int exp_bits, input bit poke);
    int  nvalid = 0, ndone = 0, first = -1, last = -1, done_cyc = -1;
    bit  want;
    for (int cyc = 0; cyc < exp_bits + 20; cyc++) begin
      if (dvalid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        nvalid++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_bit dout=%b required=none", name, dout);
        end else begin
          want = exp_q.pop_front();
          if (dout !== want) begin
            failures++;
            $display("FAIL %s bit%0d dout=%b required=%b", name, nvalid - 1, dout, want);
          end
        end
      end else begin
        checks++;
        if (dout !== 1'b0) begin
          failures++;
          $display("FAIL %s dout_when_invalid dout=%b required=0", name, dout);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        done_cyc = cyc;
        checks++;
        if (dvalid !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s done_cycle dvalid=%b busy=%b required dvalid=0 busy=1", name, dvalid, busy);
        end
        if (poke) begin
          start = 1'b1; load_pat = 1'b1; pat_in = 4'b0000; repeat_cnt = 8'd1;
        end
        cycle();
        start = 1'b0; load_pat = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dvalid !== 1'b0) begin
          failures++;
          $display("FAIL %s after_done busy=%b done=%b dvalid=%b required 0 0 0", name, busy, done, dvalid);
        end
        break;
      end
      if (poke && nvalid == 2) begin
        start = 1'b1; load_pat = 1'b1; pat_in = 4'b0000; repeat_cnt = 8'd5;
      end else begin
        start = 1'b0; load_pat = 1'b0;
      end
      cycle();
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL %s done_count got=%0d required=1", name, ndone);
    end
    checks++;
    if (done_cyc != exp_bits) begin
      failures++;
      $display("FAIL %s done_cycle_index got=%0d required=%0d", name, done_cyc, exp_bits);
    end
    checks++;
    if (nvalid != exp_bits) begin
      failures++;
      $display("FAIL %s valid_count got=%0d required=%0d", name, nvalid, exp_bits);
    end
    if (exp_bits > 0) begin
      checks++;
      if (last - first + 1 != nvalid) begin
        failures++;
        $display("FAIL %s contiguous span=%0d valid=%0d", name, last - first + 1, nvalid);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s leftover got=%0d required=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (dout !== 1'b0 || dvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s dout=%b dvalid=%b busy=%b done=%b required all 0", name, dout, dvalid, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; load_pat = 1'b0; pat_in = '0; repeat_cnt = '0;
    repeat (3) cycle();
    check_idle("reset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_idle("idle_after_reset");
    end
  endtask

  task automatic test_single_frame();
    push_frames(4'b1011, 1);
    do_start(8'd1, 1'b0, 4'b0000);
    collect("single_frame", exp_q.size(), 1'b0);
  endtask

  task automatic test_load_then_burst();
    load_pat = 1'b1; pat_in = 4'b0110;
    cycle();
    load_pat = 1'b0;
    check_idle("idle_after_load");
    push_frames(4'b0110, 3);
    do_start(8'd3, 1'b0, 4'b1111);
    collect("load_burst3", exp_q.size(), 1'b0);
  endtask

  task automatic test_load_with_start();
    push_frames(4'b1100, 2);
    do_start(8'd2, 1'b1, 4'b1100);
    collect("load_with_start", exp_q.size(), 1'b0);
  endtask

  task automatic test_zero_frames();
    do_start(8'd0, 1'b0, 4'b0000);
    collect("zero_frames", 0, 1'b0);
  endtask

  task automatic test_reset_abort();
    do_start(8'd3, 1'b0, 4'b0000);
    cycle();
    checks++;
    if (dvalid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_precond dvalid=%b busy=%b required 1 1", dvalid, busy);
    end
    rst_n = 1'b0;
    #1;
    check_idle("abort_async");
    cycle();
    check_idle("abort_held");
    rst_n = 1'b1;
    cycle();
    check_idle("abort_released");
    push_frames(4'b1011, 1);
    do_start(8'd1, 1'b0, 4'b0000);
    collect("after_abort", exp_q.size(), 1'b0);
  endtask

  task automatic test_ignore_during_burst();
    push_frames(4'b1011, 2);
    do_start(8'd2, 1'b0, 4'b0000);
    collect("ignore_start", exp_q.size(), 1'b1);
    push_frames(4'b1011, 1);
    do_start(8'd1, 1'b0, 4'b0000);
    collect("pattern_kept", exp_q.size(), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [PAT_W-1:0] p;
    logic [CNT_W-1:0] n;
    for (int t = 0; t < 3; t++) begin
      p = PAT_W'($urandom);
      n = CNT_W'($urandom_range(1, 6));
      push_frames(p, int'(n));
      do_start(n, 1'b1, p);
      collect("random_burst", exp_q.size(), 1'b0);
    end
    push_frames(4'b1001, 255);
    do_start(8'd255, 1'b1, 4'b1001);
    collect("max_burst", exp_q.size(), 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_load_then_burst();
    test_load_with_start();
    test_zero_frames();
    test_reset_abort();
    test_ignore_during_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
